// File: rtl/seq_mult_param.sv
// Shift-and-add sequential multiplier, WIDTH x WIDTH -> 2*WIDTH, with
// runtime signed/unsigned operands and early exit once no multiplier bits remain.
module seq_mult_param #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]         r_state;
  logic [WIDTH-1:0]   r_mag_a;
  logic [WIDTH-1:0]   r_mag_b;
  logic               r_neg;
  logic [2*WIDTH-1:0] r_acc;
  logic [CW-1:0]      r_count;
  logic [2*WIDTH-1:0] r_product;

  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [2*WIDTH-1:0] w_mcand;
  logic [2*WIDTH-1:0] w_acc_next;
  logic [WIDTH-1:0]   w_mag_b_sh;
  logic               w_last;

  // Magnitude of the most-negative value wraps to 2^(WIDTH-1), which is the
  // correct unsigned magnitude, so no special case is needed.
  assign w_abs_a    = (signed_mode && a[WIDTH-1]) ? -a : a;
  assign w_abs_b    = (signed_mode && b[WIDTH-1]) ? -b : b;

  assign w_mcand    = {{WIDTH{1'b0}}, r_mag_a} << r_count;
  assign w_acc_next = r_acc + (r_mag_b[0] ? w_mcand : '0);
  assign w_mag_b_sh = r_mag_b >> 1;
  assign w_last     = (r_count == CW'(WIDTH-1)) || (w_mag_b_sh == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_mag_a   <= '0;
      r_mag_b   <= '0;
      r_neg     <= 1'b0;
      r_acc     <= '0;
      r_count   <= '0;
      r_product <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mag_a <= w_abs_a;
            r_mag_b <= w_abs_b;
            r_neg   <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
            r_acc   <= '0;
            r_count <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_acc   <= w_acc_next;
          r_mag_b <= w_mag_b_sh;
          r_count <= r_count + 1'b1;
          if (w_last) begin
            r_product <= r_neg ? -w_acc_next : w_acc_next;
            r_state   <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Outputs decode state flops only; nothing from the inputs reaches them.
  assign busy    = (r_state != S_IDLE);
  assign done    = (r_state == S_DONE);
  assign product = r_product;

endmodule

// File: tb/tb_seq_mult_param.sv
// Directed bench for seq_mult_param: latency, products, back-to-back, ignored
// restart and reset abort, with hand-computed expectations.
module tb_seq_mult_param;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic           signed_mode;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  int n_chk  = 0;
  int n_err  = 0;
  int n_done = 0;

  seq_mult_param #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .signed_mode(signed_mode),
    .a(a), .b(b), .busy(busy), .done(done), .product(product)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done) n_done++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; leaves the bench at the negedge of the cycle after done.
  task automatic run_op(input string tag, input logic sm, input logic [W-1:0] ia,
                        input logic [W-1:0] ib, input logic [15:0] exp_p,
                        input int exp_n, input bit repulse);
    int n;
    int d0;
    d0 = n_done;
    signed_mode = sm; a = ia; b = ib; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy"}, busy, 1);
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (repulse && n == 1) begin
        start = 1'b1; a = 8'd1; b = 8'd1; signed_mode = 1'b0;
      end else if (repulse && n == 2) begin
        start = 1'b0;
      end
      if (done) break;
    end
    chk({tag, "_lat"}, n, exp_n);
    chk({tag, "_prod"}, product, exp_p);
    @(negedge clk);
    chk({tag, "_idle"}, {busy, done}, 0);
    chk({tag, "_pulses"}, n_done - d0, 1);
  endtask

  initial begin
    int d0;
    reset = 1'b1; start = 1'b0; signed_mode = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_prod", product, 0);
    reset = 1'b0;
    @(negedge clk);

    run_op("u13x11",  1'b0, 8'd13,  8'd11,  16'd143,   4, 1'b0);
    @(negedge clk);
    run_op("u255",    1'b0, 8'd255, 8'd255, 16'hFE01,  8, 1'b0);
    run_op("sm3x5",   1'b1, 8'hFD,  8'd5,   16'hFFF1,  3, 1'b0);
    run_op("sm128sq", 1'b1, 8'h80,  8'h80,  16'h4000,  8, 1'b0);
    run_op("s127xm",  1'b1, 8'd127, 8'h80,  16'hC080,  8, 1'b0);
    run_op("u_b0",    1'b0, 8'd200, 8'd0,   16'd0,     1, 1'b0);
    run_op("b2b",     1'b0, 8'd2,   8'd3,   16'd6,     2, 1'b0);
    run_op("s_b0",    1'b1, 8'hF9,  8'd0,   16'd0,     1, 1'b0);
    run_op("repulse", 1'b0, 8'd13,  8'd11,  16'd143,   4, 1'b1);
    d0 = n_done;
    repeat (3) @(negedge clk);
    chk("repulse_noq", n_done - d0, 0);

    // Abort 255x255 with reset sampled at edge k+2.
    d0 = n_done;
    signed_mode = 1'b0; a = 8'd255; b = 8'd255; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_prod", product, 0);
    repeat (10) @(negedge clk);
    chk("abort_nodone", n_done - d0, 0);
    chk("abort_hold", product, 0);

    run_op("u4x4", 1'b0, 8'd4, 8'd4, 16'd16, 3, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/seq_mult_param.md
Name: seq_mult_param

Overview:
- Parametrised shift-and-add sequential multiplier, WIDTH x WIDTH -> 2*WIDTH.
- Supports runtime-selectable signed (two's complement) or unsigned operands.
- Terminates early once no set multiplier bits remain.
- Uses a start/busy/done handshake. Serves as the shared arithmetic unit for datapath blocks that cannot afford a combinational multiplier.

Parameters:
- WIDTH, 8, operand width in bits (>= 2); product width is 2*WIDTH.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- signed_mode  input  1  1 = operands are two's complement, 0 = unsigned; sampled with start.
- a  input  WIDTH  multiplicand; sampled with start.
- b  input  WIDTH  multiplier; sampled with start.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse; product is valid.
- product  output  2*WIDTH  result; held until the next done.

Behaviour:
- One clock domain. Reset is synchronous and active-high; reset wins over every other input.
- Reset values: state=IDLE, busy=0, done=0, product=0, all internal registers 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 captures mag_a=|a| and mag_b=|b|. Absolute value is taken only if signed_mode=1; otherwise the raw value is used. Both are held as WIDTH-bit unsigned.
  - Also captures neg = signed_mode & (a[MSB]^b[MSB]); clears acc (2*WIDTH) and count; goes to RUN.
  - start=0: stay in IDLE.
- RUN (one multiplier bit per cycle):
  - acc_next = acc + (mag_b[0] ? mcand : 0), where mcand is mag_a zero-extended to 2*WIDTH and shifted left by count.
  - Shift mag_b right by 1; count increments.
  - Exit to DONE when count==WIDTH-1 or (mag_b>>1)==0. RUN therefore always lasts at least one cycle.
  - On the exit edge: product <= neg ? -acc_next : acc_next (2*WIDTH two's complement).
- DONE: done=1 for exactly one cycle; next state is IDLE unconditionally.
- Latency: with start sampled at edge k, done is high in the cycle after edge k+N. N = max(1, index of highest set bit of mag_b + 1), with N <= WIDTH.
- A new start may be sampled in the cycle immediately after done (back-to-back throughput N+2 cycles).
- start while busy=1 is ignored: no effect on the in-flight operation and no queuing.
- Changes on a, b or signed_mode while busy have no effect.
- Signed edge case: magnitude of the most-negative value is 2^(WIDTH-1), representable as WIDTH-bit unsigned. (-2^(W-1))^2 = 2^(2W-2) fits the 2*WIDTH signed result.
- Overflow is impossible; no saturation.
- product changes only on the RUN->DONE edge and on reset. It is stable in IDLE and during RUN of the next operation.
- Reset asserted during RUN or DONE: next cycle is IDLE with product=0. No done pulse is issued for the aborted operation.
- done and busy are registered outputs; no combinational path from inputs to outputs.

Test Plan:
- WIDTH=8, unsigned, a=13, b=11, start at edge k:
  - busy=1 from k+1.
  - done high after edge k+4 (N=4).
  - product=16'd143.
  - busy=0 the following cycle.
- Unsigned a=255, b=255 -> N=8, product=16'hFE01. Signed a=-3 (8'hFD), b=5 -> N=3, product=16'hFFF1.
- Signed a=-128, b=-128 -> N=8, product=16'h4000. Signed a=127, b=-128 -> product=16'hC080.
- b=0 (any a, either mode) -> N=1, done after edge k+1, product=0. Then a back-to-back start the cycle after done (a=2, b=3 unsigned) -> product=6 with N=2.
- start re-pulsed with a=1, b=1 while busy during a=13, b=11 -> ignored; product=143 and only one done pulse.
- reset during RUN (edge k+2 of a 255x255 op) -> next cycle busy=0, done never pulses, product=0. A subsequent start with a=4, b=4 -> product=16.
